uart_rx_cmd_decoder: RTL and testbench

//  Consumes bytes from the UART receiver and buffers them in a small FIFO.

---
 rtl/uart_pkg.sv | 52 +++++
 rtl/uart_byte_fifo.sv | 59 +++++
 rtl/uart_rx_cmd_decoder.sv | 153 +++++++++++++++
 tb/tb_uart_rx_cmd_decoder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side command decoder.
//   BYTE_W                     width of a UART payload byte
//   CMD_PARITY/STOP/RESET      link-config command bytes
//   SEG_BLANK                  all segments off (active-low)
//   state_e                    decoder FSM states
//   seg_glyph(byte)            byte -> active-low {g,f,e,d,c,b,a} pattern
package uart_pkg;

  localparam int         BYTE_W     = 8;
  localparam logic [7:0] CMD_PARITY = 8'hFE;
  localparam logic [7:0] CMD_STOP   = 8'hFD;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_POP     = 2'd1,
    S_EXEC    = 2'd2,
    S_WAIT_TX = 2'd3
  } state_e;

  // Anything that is neither a digit nor one of the supported letters blanks
  // the display.
  function automatic logic [6:0] seg_glyph(input logic [7:0] b);
    logic [6:0] g;
    case (b)
      8'h30:   g = 7'h40;  // 0
      8'h31:   g = 7'h79;  // 1
      8'h32:   g = 7'h24;  // 2
      8'h33:   g = 7'h30;  // 3
      8'h34:   g = 7'h19;  // 4
      8'h35:   g = 7'h12;  // 5
      8'h36:   g = 7'h02;  // 6
      8'h37:   g = 7'h78;  // 7
      8'h38:   g = 7'h00;  // 8
      8'h39:   g = 7'h10;  // 9
      8'h41:   g = 7'h08;  // A
      8'h42:   g = 7'h03;  // b
      8'h43:   g = 7'h46;  // C
      8'h44:   g = 7'h21;  // d
      8'h45:   g = 7'h06;  // E
      8'h46:   g = 7'h0E;  // F
      8'h48:   g = 7'h09;  // H
      8'h49:   g = 7'h79;  // I
      8'h4C:   g = 7'h47;  // L
      8'h4E:   g = 7'h2B;  // n
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with registered read port.
//   clk, rst_n   clock, asynchronous active-low reset (pointers/count only)
//   push, wdata  write strobe and byte; caller must not push when full
//                unless it pops in the same cycle
//   pop          read strobe; rdata holds the popped byte from the next cycle
//   full, empty  occupancy flags
//   count        bytes currently stored (0 .. 2**DEPTH_LOG2)
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [BYTE_W-1:0]     wdata,
  output logic [BYTE_W-1:0]     rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [BYTE_W-1:0]     mem_q [DEPTH];
  logic [BYTE_W-1:0]     rdata_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;

  // Pointers are exactly DEPTH_LOG2 bits wide, so increments wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage and read register carry no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
    if (pop)  rdata_q <= mem_q[rd_ptr_q];
  end

  assign rdata = rdata_q;
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == (DEPTH_LOG2+1)'(DEPTH));

endmodule

// File: rtl/uart_rx_cmd_decoder.sv
// Buffers bytes from the UART receiver and executes them one at a time:
// digits/letters drive the 7-segment digit, 0xFE/0xFD/0xFF reconfigure the
// link (parity, stop bits, config reset).
// Optional feature macro: UART_ECHO_EN (echo executed bytes to UART TX).
//   CLOCK_50      system clock
//   rst_n         asynchronous active-low reset
//   rx_data       received byte, qualified by rx_valid
//   rx_valid      one-cycle strobe per received byte
//   rx_frame_err  1 = byte had a framing/parity error and is discarded
//   parity_en     1 = even parity bit on the link
//   stop_two      1 = two stop bits on the link
//   hex           active-low segments {g,f,e,d,c,b,a}
//   last_byte     last executed byte
//   overflow      sticky, set when a byte was dropped on a full FIFO
//   fifo_count    bytes buffered
//   tx_data/tx_valid/tx_ready  (UART_ECHO_EN only) valid/ready echo channel
module uart_rx_cmd_decoder
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                rx_frame_err,
  output logic                parity_en,
  output logic                stop_two,
  output logic [6:0]          hex,
  output logic [7:0]          last_byte,
  output logic                overflow,
  output logic [DEPTH_LOG2:0] fifo_count
`ifdef UART_ECHO_EN
  ,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready
`endif
);

  state_e     state_q;
  logic       parity_q, stop_q, ovf_q;
  logic [6:0] hex_q;
  logic [7:0] last_q;
`ifdef UART_ECHO_EN
  logic [7:0] tx_data_q;
  logic       tx_valid_q;
`endif

  logic       fifo_full, fifo_empty, fifo_push, fifo_pop, drop;
  logic [7:0] fifo_rdata;
  logic       parity_d, stop_d;
  logic [6:0] hex_d;

  // A byte may enter a full FIFO only when a slot frees up in the same cycle.
  assign fifo_pop  = (state_q == S_POP);
  assign fifo_push = rx_valid & ~rx_frame_err & (~fifo_full | fifo_pop);
  assign drop      = rx_valid & ~rx_frame_err & fifo_full & ~fifo_pop;

  uart_byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (rx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Effect of executing the byte currently in the FIFO read register.
  always_comb begin
    parity_d = parity_q;
    stop_d   = stop_q;
    hex_d    = hex_q;
    case (fifo_rdata)
      CMD_PARITY: parity_d = ~parity_q;
      CMD_STOP:   stop_d   = ~stop_q;
      CMD_RESET: begin
        parity_d = 1'b0;
        stop_d   = 1'b0;
        hex_d    = SEG_BLANK;
      end
      default:    hex_d    = seg_glyph(fifo_rdata);
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      parity_q   <= 1'b0;
      stop_q     <= 1'b0;
      hex_q      <= SEG_BLANK;
      last_q     <= 8'h00;
      ovf_q      <= 1'b0;
`ifdef UART_ECHO_EN
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (!fifo_empty) state_q <= S_POP;
        S_POP:  state_q <= S_EXEC;
        S_EXEC: begin
          last_q   <= fifo_rdata;
          parity_q <= parity_d;
          stop_q   <= stop_d;
          hex_q    <= hex_d;
          if (fifo_rdata == CMD_RESET) ovf_q <= 1'b0;
`ifdef UART_ECHO_EN
          // Config commands (0xFD..0xFF) are consumed silently.
          if (fifo_rdata < CMD_STOP) begin
            tx_data_q  <= fifo_rdata;
            tx_valid_q <= 1'b1;
            state_q    <= S_WAIT_TX;
          end else begin
            state_q    <= S_IDLE;
          end
`else
          state_q  <= S_IDLE;
`endif
        end
        S_WAIT_TX: begin
`ifdef UART_ECHO_EN
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
`else
          state_q <= S_IDLE;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
      // A drop in the same cycle as a 0xFF execute still leaves the flag set.
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign parity_en = parity_q;
  assign stop_two  = stop_q;
  assign hex       = hex_q;
  assign last_byte = last_q;
  assign overflow  = ovf_q;
`ifdef UART_ECHO_EN
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
`endif

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Bench for uart_rx_cmd_decoder: directed vector table, hand-written corner
// sequences (overflow burst, frame error, reset mid-execute, echo hold) and a
// randomized byte stream against a behavioural model of the decoder.
module tb_uart_rx_cmd_decoder;

  localparam int DL2 = 3;

  logic           CLOCK_50 = 1'b0;
  logic           rst_n;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           rx_frame_err;
  logic           parity_en, stop_two, overflow;
  logic [6:0]     hex;
  logic [7:0]     last_byte;
  logic [DL2:0]   fifo_count;
`ifdef UART_ECHO_EN
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
`endif

  uart_rx_cmd_decoder #(.DEPTH_LOG2(DL2)) dut (
    .CLOCK_50     (CLOCK_50),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .parity_en    (parity_en),
    .stop_two     (stop_two),
    .hex          (hex),
    .last_byte    (last_byte),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
`ifdef UART_ECHO_EN
    ,
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] m_hex;
  logic [7:0] m_last;
  logic       m_par, m_stop, m_ovf;

  // Glyph table written as the 8-bit display codes (bit 7 unused).
  function automatic logic [6:0] ref_glyph(input logic [7:0] b);
    logic [7:0] g;
    case (b)
      8'h30: g = 8'hC0;  8'h31: g = 8'hF9;  8'h32: g = 8'hA4;  8'h33: g = 8'hB0;
      8'h34: g = 8'h99;  8'h35: g = 8'h92;  8'h36: g = 8'h82;  8'h37: g = 8'hF8;
      8'h38: g = 8'h80;  8'h39: g = 8'h90;
      8'h41: g = 8'h88;  8'h42: g = 8'h83;  8'h43: g = 8'hC6;  8'h44: g = 8'hA1;
      8'h45: g = 8'h86;  8'h46: g = 8'h8E;  8'h48: g = 8'h89;  8'h49: g = 8'hF9;
      8'h4C: g = 8'hC7;  8'h4E: g = 8'hAB;
      default: g = 8'hFF;
    endcase
    return g[6:0];
  endfunction

  task automatic model_reset();
    m_hex = 7'h7F; m_last = 8'h00; m_par = 1'b0; m_stop = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_exec(input logic [7:0] b);
    m_last = b;
    if (b == 8'hFE)      m_par  = ~m_par;
    else if (b == 8'hFD) m_stop = ~m_stop;
    else if (b == 8'hFF) begin m_par = 1'b0; m_stop = 1'b0; m_ovf = 1'b0; m_hex = 7'h7F; end
    else                 m_hex  = ref_glyph(b);
  endtask

  // ---------------- stimulus helpers ----------------
  // Drive a byte for one clock; returns at the negedge of the following cycle.
  task automatic send(input logic [7:0] b, input logic ferr);
    rx_data = b; rx_frame_err = ferr; rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0; rx_frame_err = 1'b0;
  endtask

  // One byte into an idle decoder: count after one cycle, outputs still old
  // one cycle before the 4-cycle latency, then the model is advanced.
  task automatic apply(input logic [7:0] b, input logic ferr, input string tag);
    logic [6:0] pre_hex;
    pre_hex = m_hex;
    send(b, ferr);
    chk({tag, " count+1"}, 32'(fifo_count), ferr ? 32'd0 : 32'd1);
    repeat (2) @(negedge CLOCK_50);
    chk({tag, " hex early"}, 32'(hex), 32'(pre_hex));
    @(negedge CLOCK_50);
    if (!ferr) model_exec(b);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " hex"},    32'(hex),        32'(m_hex));
    chk({tag, " par"},    32'(parity_en),  32'(m_par));
    chk({tag, " stop"},   32'(stop_two),   32'(m_stop));
    chk({tag, " last"},   32'(last_byte),  32'(m_last));
    chk({tag, " ovf"},    32'(overflow),   32'(m_ovf));
    chk({tag, " count"},  32'(fifo_count), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " hex"},   32'(hex),        32'h7F);
    chk({tag, " par"},   32'(parity_en),  32'd0);
    chk({tag, " stop"},  32'(stop_two),   32'd0);
    chk({tag, " last"},  32'(last_byte),  32'd0);
    chk({tag, " ovf"},   32'(overflow),   32'd0);
    chk({tag, " count"}, 32'(fifo_count), 32'd0);
`ifdef UART_ECHO_EN
    chk({tag, " txv"},   32'(tx_valid),   32'd0);
`endif
  endtask

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic [6:0] hex;
    logic       par;
    logic       stop;
    logic [7:0] last;
  } vec_t;

  vec_t tbl [21];

  initial begin
    tbl[0]  = '{8'h37, 1'b0, 7'h78, 1'b0, 1'b0, 8'h37};
    tbl[1]  = '{8'hFE, 1'b0, 7'h78, 1'b1, 1'b0, 8'hFE};
    tbl[2]  = '{8'hFD, 1'b0, 7'h78, 1'b1, 1'b1, 8'hFD};
    tbl[3]  = '{8'hFF, 1'b0, 7'h7F, 1'b0, 1'b0, 8'hFF};
    tbl[4]  = '{8'h31, 1'b1, 7'h7F, 1'b0, 1'b0, 8'hFF};
    tbl[5]  = '{8'h41, 1'b0, 7'h08, 1'b0, 1'b0, 8'h41};
    tbl[6]  = '{8'h42, 1'b0, 7'h03, 1'b0, 1'b0, 8'h42};
    tbl[7]  = '{8'h43, 1'b0, 7'h46, 1'b0, 1'b0, 8'h43};
    tbl[8]  = '{8'h44, 1'b0, 7'h21, 1'b0, 1'b0, 8'h44};
    tbl[9]  = '{8'h45, 1'b0, 7'h06, 1'b0, 1'b0, 8'h45};
    tbl[10] = '{8'h46, 1'b0, 7'h0E, 1'b0, 1'b0, 8'h46};
    tbl[11] = '{8'h48, 1'b0, 7'h09, 1'b0, 1'b0, 8'h48};
    tbl[12] = '{8'h49, 1'b0, 7'h79, 1'b0, 1'b0, 8'h49};
    tbl[13] = '{8'h4C, 1'b0, 7'h47, 1'b0, 1'b0, 8'h4C};
    tbl[14] = '{8'h4E, 1'b0, 7'h2B, 1'b0, 1'b0, 8'h4E};
    tbl[15] = '{8'h39, 1'b0, 7'h10, 1'b0, 1'b0, 8'h39};
    tbl[16] = '{8'h30, 1'b0, 7'h40, 1'b0, 1'b0, 8'h30};
    tbl[17] = '{8'h5A, 1'b0, 7'h7F, 1'b0, 1'b0, 8'h5A};
    tbl[18] = '{8'hFE, 1'b0, 7'h7F, 1'b1, 1'b0, 8'hFE};
    tbl[19] = '{8'h38, 1'b0, 7'h00, 1'b1, 1'b0, 8'h38};
    tbl[20] = '{8'hFF, 1'b0, 7'h7F, 1'b0, 1'b0, 8'hFF};

    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_frame_err = 1'b0;
`ifdef UART_ECHO_EN
    tx_ready = 1'b1;
`endif
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // Directed table.
    for (int i = 0; i < 21; i++) begin
      string tag;
      tag = $sformatf("tbl%0d", i);
      apply(tbl[i].data, tbl[i].ferr, tag);
      chk({tag, " hex"},  32'(hex),       32'(tbl[i].hex));
      chk({tag, " par"},  32'(parity_en), 32'(tbl[i].par));
      chk({tag, " stop"}, 32'(stop_two),  32'(tbl[i].stop));
      chk({tag, " last"}, 32'(last_byte), 32'(tbl[i].last));
      chk({tag, " count"}, 32'(fifo_count), 32'd0);
    end

    // Overflow burst: 15 back-to-back bytes 0x60..0x6E. The decoder drains one
    // byte every 3 cycles (4 with echo and tx_ready=1), first pop 2 cycles
    // after the first push, so the FIFO fills and the bytes at indices 12,13
    // (11,12,13 with echo) are dropped while index 14 coincides with a pop.
    begin
      bit dropped_seen;
      bit drained;
      dropped_seen = 1'b0;
      drained = 1'b0;
      for (int i = 0; i < 15; i++) begin
        rx_data = 8'h60 + 8'(i); rx_valid = 1'b1;
        @(negedge CLOCK_50);
      end
      rx_valid = 1'b0;
      chk("burst count full", 32'(fifo_count), 32'd8);
      chk("burst ovf", 32'(overflow), 32'd1);
      for (int c = 0; c < 80 && !drained; c++) begin
        @(negedge CLOCK_50);
        if (last_byte == 8'h6C || last_byte == 8'h6D) dropped_seen = 1'b1;
`ifdef UART_ECHO_EN
        if (last_byte == 8'h6B) dropped_seen = 1'b1;
`endif
        if (fifo_count == '0 && last_byte == 8'h6E) drained = 1'b1;
      end
      chk("burst drain", 32'(drained), 32'd1);
      chk("burst dropped executed", 32'(dropped_seen), 32'd0);
      repeat (3) @(negedge CLOCK_50);
      m_last = 8'h6E; m_hex = 7'h7F; m_ovf = 1'b1;
      chk_model("burst end");
      apply(8'hFF, 1'b0, "ovf clear");
      chk_model("ovf clear");
    end

    // Reset while the first of three queued bytes is executing.
    apply(8'hFE, 1'b0, "pre-rst");
    chk_model("pre-rst");
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    send(8'h33, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async rst");
    repeat (2) @(negedge CLOCK_50);
    rst_n = 1'b1;
    model_reset();
    repeat (12) @(negedge CLOCK_50);
    chk_model("post-rst");

`ifdef UART_ECHO_EN
    // Echo held while the transmitter is busy.
    tx_ready = 1'b0;
    apply(8'h41, 1'b0, "echo");
    chk_model("echo");
    for (int c = 0; c < 10; c++) begin
      chk("echo hold valid", 32'(tx_valid), 32'd1);
      chk("echo hold data", 32'(tx_data), 32'h41);
      @(negedge CLOCK_50);
    end
    tx_ready = 1'b1;
    @(negedge CLOCK_50);
    chk("echo released", 32'(tx_valid), 32'd0);
    repeat (3) @(negedge CLOCK_50);
    chk("echo single", 32'(tx_valid), 32'd0);
    apply(8'h42, 1'b0, "after echo");
    chk_model("after echo");
    @(negedge CLOCK_50);
`endif

    // Randomized byte stream against the model.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] b;
      logic       fe;
      int         sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0: b = 8'h30 + 8'($urandom_range(0, 9));
        1: b = 8'h41 + 8'($urandom_range(0, 13));
        2: b = 8'hFD + 8'($urandom_range(0, 2));
        default: b = 8'($urandom_range(0, 255));
      endcase
      fe = ($urandom_range(0, 7) == 0);
      apply(b, fe, $sformatf("rnd%0d", i));
      chk_model($sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
